// File: rtl/v_pkg.sv
// Shared defaults and types for the vector writeback collector.
// Lane index wrap helper used by the round-robin arbiter.
package v_pkg;

    localparam int VREG_DW = 256;
    localparam int VREG_AW = 5;
    localparam int NLANE   = 3;

    typedef struct packed {
        logic [VREG_AW-1:0] vd;
        logic [VREG_DW-1:0] data;
    } wb_entry_t;

    // Single-step modular wrap; idx is always below 2*n at every call site.
    function automatic int lane_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/v_wb_fifo.sv
// Single-lane result FIFO: registered storage, power-of-two depth, wrapping pointers.
// Push on full and pop on empty are ignored.
module v_wb_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == {CW{1'b0}});
    assign count_o   = cnt_q;
    assign data_o    = mem_q[rd_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    always_comb begin
        wr_d  = push_ok_s ? (wr_q + PW'(1)) : wr_q;
        rd_d  = pop_ok_s ? (rd_q + PW'(1)) : rd_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_ok_s) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/v_wb_collector.sv
// Vector writeback collector: per-lane FIFOs, round-robin onto one VRF write
// port, and a pending-write bitmap for issue-stage hazard checks.
module v_wb_collector #(
    parameter int VREG_DW = v_pkg::VREG_DW,
    parameter int VREG_AW = v_pkg::VREG_AW,
    parameter int NLANE   = v_pkg::NLANE,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NLANE-1:0]         lane_valid_i,
    input  logic [NLANE*VREG_AW-1:0] lane_vd_i,
    input  logic [NLANE*VREG_DW-1:0] lane_result_i,
    output logic [NLANE-1:0]         lane_ready_o,
    input  logic                     vrf_stall_i,
    output logic                     vrf_we_o,
    output logic [VREG_AW-1:0]       vrf_waddr_o,
    output logic [VREG_DW-1:0]       vrf_wdata_o,
    output logic [(1<<VREG_AW)-1:0]  pending_mask_o,
    output logic                     busy_o
);
    import v_pkg::*;

    localparam int EW   = VREG_AW + VREG_DW;
    localparam int NREG = 1 << VREG_AW;
    localparam int RRW  = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int CW   = $clog2(DEPTH) + 1;

    logic [NLANE-1:0]   push_s, pop_s, full_s, empty_s;
    logic [EW-1:0]      head_s  [NLANE];
    logic [CW-1:0]      count_s [NLANE];
    logic [EW-1:0]      head_sel_s;
    logic [RRW-1:0]     rr_q, rr_d, grant_idx_s, cand_s;
    logic               grant_valid_s, grant_s, hit_s;
    logic               we_q, we_d;
    logic [VREG_AW-1:0] waddr_q, waddr_d;
    logic [VREG_DW-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]    pend_q, pend_d, set_s, clr_s;

    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        // Ready looks only at the registered count: no same-cycle pop bypass.
        assign lane_ready_o[g] = (count_s[g] < CW'(DEPTH));
        assign push_s[g]       = lane_valid_i[g] && !full_s[g];

        v_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_s[g]),
            .pop_i   (pop_s[g]),
            .data_i  ({lane_vd_i[g*VREG_AW +: VREG_AW], lane_result_i[g*VREG_DW +: VREG_DW]}),
            .data_o  (head_s[g]),
            .count_o (count_s[g]),
            .full_o  (full_s[g]),
            .empty_o (empty_s[g])
        );
    end

    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {RRW{1'b0}};
        cand_s        = {RRW{1'b0}};
        hit_s         = 1'b0;
        for (int k = 0; k < NLANE; k++) begin
            cand_s        = RRW'(lane_wrap(int'(rr_q) + k, NLANE));
            hit_s         = !grant_valid_s && !empty_s[cand_s];
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_valid_s = grant_valid_s || hit_s;
        end
        grant_s    = grant_valid_s && !vrf_stall_i;
        pop_s      = grant_s ? (NLANE'(1) << grant_idx_s) : {NLANE{1'b0}};
        head_sel_s = head_s[grant_idx_s];
    end

    always_comb begin
        we_d    = grant_s;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        if (grant_s) begin
            waddr_d = head_sel_s[EW-1 -: VREG_AW];
            wdata_d = head_sel_s[VREG_DW-1:0];
            rr_d    = RRW'(lane_wrap(int'(grant_idx_s) + 1, NLANE));
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
            rr_d    = rr_q;
        end
    end

    // A set at the same edge as a clear of that bit wins.
    always_comb begin
        set_s = {NREG{1'b0}};
        for (int i = 0; i < NLANE; i++) begin
            set_s = set_s | (push_s[i] ? (NREG'(1) << lane_vd_i[i*VREG_AW +: VREG_AW]) : {NREG{1'b0}});
        end
        clr_s  = we_q ? (NREG'(1) << waddr_q) : {NREG{1'b0}};
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q    <= {RRW{1'b0}};
            we_q    <= 1'b0;
            waddr_q <= {VREG_AW{1'b0}};
            wdata_q <= {VREG_DW{1'b0}};
            pend_q  <= {NREG{1'b0}};
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign vrf_we_o       = we_q;
    assign vrf_waddr_o    = waddr_q;
    assign vrf_wdata_o    = wdata_q;
    assign pending_mask_o = pend_q;
    assign busy_o         = (|(~empty_s)) || we_q;

endmodule

// File: tb/tb_v_wb_collector.sv
// Self-checking bench for v_wb_collector: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_v_wb_collector;
    import v_pkg::*;

    localparam int DW   = VREG_DW;
    localparam int AW   = VREG_AW;
    localparam int NL   = NLANE;
    localparam int DEP  = 2;
    localparam int NREG = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL-1:0]     lane_valid_i;
    logic [NL*AW-1:0]  lane_vd_i;
    logic [NL*DW-1:0]  lane_result_i;
    logic [NL-1:0]     lane_ready_o;
    logic              vrf_stall_i;
    logic              vrf_we_o;
    logic [AW-1:0]     vrf_waddr_o;
    logic [DW-1:0]     vrf_wdata_o;
    logic [NREG-1:0]   pending_mask_o;
    logic              busy_o;

    always #5 clk = ~clk;

    v_wb_collector #(.VREG_DW(DW), .VREG_AW(AW), .NLANE(NL), .DEPTH(DEP)) dut (
        .clk            (clk),
        .rst            (rst),
        .lane_valid_i   (lane_valid_i),
        .lane_vd_i      (lane_vd_i),
        .lane_result_i  (lane_result_i),
        .lane_ready_o   (lane_ready_o),
        .vrf_stall_i    (vrf_stall_i),
        .vrf_we_o       (vrf_we_o),
        .vrf_waddr_o    (vrf_waddr_o),
        .vrf_wdata_o    (vrf_wdata_o),
        .pending_mask_o (pending_mask_o),
        .busy_o         (busy_o)
    );

    // Reference model: one queue per lane, a round-robin start lane, the
    // expected registered write port and the set of in-flight registers.
    wb_entry_t       mq [NL][$];
    int              m_rr;
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [DW-1:0]   m_wdata;
    logic [NREG-1:0] m_pend;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mq[i].delete();
        m_rr    = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_pend  = '0;
    endtask

    task automatic check_outputs();
        logic [NL-1:0] er;
        logic          eb;
        eb = m_we;
        for (int i = 0; i < NL; i++) begin
            er[i] = (mq[i].size() < DEP);
            if (mq[i].size() > 0) eb = 1'b1;
        end
        check_eq("ready", lane_ready_o, er);
        check_eq("we", vrf_we_o, m_we);
        if (m_we) begin
            check_eq("waddr", vrf_waddr_o, m_waddr);
            check_eq("wdata", vrf_wdata_o, m_wdata);
        end
        check_eq("pending", pending_mask_o, m_pend);
        check_eq("busy", busy_o, eb);
    endtask

    // One clock: check state at the falling edge, drive inputs, advance the model.
    task automatic cycle(input logic [NL-1:0] v, input logic [NL*AW-1:0] vd,
                         input logic [NL*DW-1:0] d, input logic st);
        logic [NL-1:0]   acc;
        logic [NREG-1:0] np;
        wb_entry_t       e;
        bit              won;
        int              j;
        @(negedge clk);
        check_outputs();
        lane_valid_i  = v;
        lane_vd_i     = vd;
        lane_result_i = d;
        vrf_stall_i   = st;
        for (int i = 0; i < NL; i++) acc[i] = v[i] && (mq[i].size() < DEP);
        np = m_pend;
        if (m_we) np[m_waddr] = 1'b0;
        won = 0;
        if (!st) begin
            for (int k = 0; k < NL; k++) begin
                j = (m_rr + k) % NL;
                if (!won && mq[j].size() > 0) begin
                    won     = 1;
                    e       = mq[j].pop_front();
                    m_waddr = e.vd;
                    m_wdata = e.data;
                    m_rr    = (j + 1) % NL;
                end
            end
        end
        m_we = won;
        for (int i = 0; i < NL; i++) begin
            if (acc[i]) begin
                e.vd   = vd[i*AW +: AW];
                e.data = d[i*DW +: DW];
                mq[i].push_back(e);
                np[e.vd] = 1'b1;
            end
        end
        m_pend = np;
        @(posedge clk);
    endtask

    function automatic logic [NL*AW-1:0] vd3(input int a, input int b, input int c);
        return {AW'(c), AW'(b), AW'(a)};
    endfunction

    function automatic logic [NL*DW-1:0] dat3(input int k);
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*DW +: DW] = {(DW/32){32'(k * 16 + i + 1)}};
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        lane_valid_i  = '0;
        lane_vd_i     = '0;
        lane_result_i = '0;
        vrf_stall_i   = 1'b0;
        rst           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", lane_ready_o, 3'b111);
        check_eq("rst_we", vrf_we_o, 1'b0);
        check_eq("rst_pend", pending_mask_o, 32'h0);
        check_eq("rst_busy", busy_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [NL*DW-1:0] a5;
        logic [AW-1:0]    ord [3];
        logic [NREG-1:0]  used;
        logic [NL*AW-1:0] rvd;
        logic [NL*DW-1:0] rd;
        int               r;

        do_reset();

        // Single write from lane 0.
        a5 = '0;
        a5[DW-1:0] = {(DW/8){8'hA5}};
        cycle(3'b001, vd3(3, 0, 0), a5, 1'b0);
        #1 check_eq("t1_pend3", pending_mask_o[3], 1'b1);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("t1_we", vrf_we_o, 1'b1);
        check_eq("t1_waddr", vrf_waddr_o, 5'd3);
        check_eq("t1_wdata", vrf_wdata_o, a5[DW-1:0]);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("t1_pend_clr", pending_mask_o[3], 1'b0);
        check_eq("t1_busy", busy_o, 1'b0);

        // Three lanes at once from rr_ptr=0, then a second round.
        do_reset();
        cycle(3'b111, vd3(1, 2, 3), dat3(1), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle('0, '0, '0, 1'b0);
            #1 ord[i] = vrf_waddr_o;
        end
        check_eq("rr_a0", ord[0], 5'd1);
        check_eq("rr_a1", ord[1], 5'd2);
        check_eq("rr_a2", ord[2], 5'd3);
        cycle(3'b111, vd3(4, 5, 6), dat3(2), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle('0, '0, '0, 1'b0);
            #1 ord[i] = vrf_waddr_o;
        end
        check_eq("rr_b0", ord[0], 5'd4);
        check_eq("rr_b1", ord[1], 5'd5);
        check_eq("rr_b2", ord[2], 5'd6);
        idle(2);

        // Lane 1 held valid under a 5-cycle stall.
        for (int i = 0; i < 5; i++) begin
            cycle(3'b010, vd3(0, 8 + i, 0), dat3(10 + i), 1'b1);
            if (i == 1) #1 check_eq("stall_ready1", lane_ready_o[1], 1'b0);
        end
        #1 check_eq("stall_we", vrf_we_o, 1'b0);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("stall_w0", vrf_waddr_o, 5'd8);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("stall_w1", vrf_waddr_o, 5'd9);
        check_eq("stall_w1we", vrf_we_o, 1'b1);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("stall_done", vrf_we_o, 1'b0);

        // Clear and set of vd=7 at the same edge.
        cycle(3'b001, vd3(7, 0, 0), dat3(20), 1'b0);
        cycle('0, '0, '0, 1'b0);
        cycle(3'b001, vd3(7, 0, 0), dat3(21), 1'b0);
        #1 check_eq("same_edge_p7", pending_mask_o[7], 1'b1);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("same_edge_p7b", pending_mask_o[7], 1'b1);
        cycle('0, '0, '0, 1'b0);
        #1 check_eq("same_edge_clr", pending_mask_o[7], 1'b0);

        // Asynchronous reset with two entries buffered and a write on the port.
        cycle(3'b111, vd3(20, 21, 22), dat3(30), 1'b0);
        cycle('0, '0, '0, 1'b0);
        #2 rst = 1'b0;
        #1 check_eq("arst_we", vrf_we_o, 1'b0);
        check_eq("arst_waddr", vrf_waddr_o, 5'd0);
        check_eq("arst_wdata", vrf_wdata_o, '0);
        check_eq("arst_pend", pending_mask_o, 32'h0);
        check_eq("arst_busy", busy_o, 1'b0);
        check_eq("arst_ready", lane_ready_o, 3'b111);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // Random traffic; vd values are kept unique among in-flight writes.
        for (int n = 0; n < 10000; n++) begin
            used = m_pend;
            for (int i = 0; i < NL; i++) begin
                do r = $urandom_range(NREG - 1, 0); while (used[r]);
                used[r] = 1'b1;
                rvd[i*AW +: AW] = AW'(r);
                for (int w = 0; w < DW / 32; w++) rd[i*DW + w*32 +: 32] = $urandom;
            end
            cycle(NL'($urandom_range(7, 0)) & NL'($urandom_range(7, 0) | $urandom_range(7, 0)),
                  rvd, rd, ($urandom_range(4, 0) == 0));
        end
        idle(12);
        #1 check_eq("drain_busy", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
